// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter slice.
//   REQ_N         number of requesters sharing the ALU
//   ALU_*         ALUFun codes understood by the shared ALU
//   slot_state_e  per-requester slot lifecycle IDLE -> ISSUED -> DONE -> IDLE
package alu_share_arbiter_pkg;

  localparam int unsigned REQ_N = 2;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_LTZ = 6'b111010;
  localparam logic [5:0] ALU_GEZ = 6'b111001;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_ISSUED = 2'd1,
    SLOT_DONE   = 2'd2
  } slot_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester channel of the ALU share arbiter: request handshake plus
// buffered response with ack.
//   valid/ready        request handshake (accept on valid && ready)
//   a/b/fun/sign       operands, ALUFun code and signed select
//   rsp_valid/rsp_ack  response held until acked
//   rsp_s/rsp_zvn      ALU S and {Z,V,N}
// Modports: master = requester, slave = arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FUN_W  = 6
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [FUN_W-1:0]  fun;
  logic              sign;
  logic              rsp_valid;
  logic              rsp_ack;
  logic [DATA_W-1:0] rsp_s;
  logic [2:0]        rsp_zvn;

  modport master (
    output valid, a, b, fun, sign, rsp_ack,
    input  ready, rsp_valid, rsp_s, rsp_zvn
  );

  modport slave (
    input  valid, a, b, fun, sign, rsp_ack,
    output ready, rsp_valid, rsp_s, rsp_zvn
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Two-way grant for the shared ALU.
//   clk, reset  clock and synchronous active-high reset (round-robin build only)
//   elig        requester N present and its slot idle
//   gnt         one-hot (or zero) grant, combinational from elig and rr_ptr
// Build option ALU_ARB_FIXED_PRIO_EN: requester 1 always wins and rr_ptr is
// removed. Otherwise a tie goes to rr_ptr, and rr_ptr then points at the
// side that was not granted.
module alu_rr_arbiter
  import alu_share_arbiter_pkg::*;
(
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic             clk,
  input  logic             reset,
`endif
  input  logic [REQ_N-1:0] elig,
  output logic [REQ_N-1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = elig;
    if (elig[1]) gnt[0] = 1'b0;
  end
`else
  logic rr_ptr_q;
  logic rr_ptr_d;

  always_comb begin
    gnt = elig;
    if (elig == '1) gnt = rr_ptr_q ? 2'b10 : 2'b01;
    rr_ptr_d = rr_ptr_q;
    if (gnt[0])      rr_ptr_d = 1'b1;
    else if (gnt[1]) rr_ptr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= 1'b0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the EX datapath (req0) and the
// branch/compare unit (req1). An accepted request is registered onto alu_*
// (stage0); one cycle later the ALU result is captured into that requester's
// response buffer, where it is held until acked.
//   clk, reset        clock, synchronous active-high reset
//   req0, req1        requester channels (alu_share_arbiter_if.slave)
//   alu_a/b/fun/sign  registered operands to the shared ALU
//   alu_s/z/v/n       ALU result inputs
// Build option ALU_ARB_FIXED_PRIO_EN: fixed priority to req1 (see alu_rr_arbiter).
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FUN_W  = 6
) (
  input  logic               clk,
  input  logic               reset,
  alu_share_arbiter_if.slave req0,
  alu_share_arbiter_if.slave req1,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [FUN_W-1:0]   alu_fun,
  output logic               alu_sign,
  input  logic [DATA_W-1:0]  alu_s,
  input  logic               alu_z,
  input  logic               alu_v,
  input  logic               alu_n
);

  logic [REQ_N-1:0]  req_valid, req_sign, rsp_ack, elig, gnt;
  logic [DATA_W-1:0] req_a   [REQ_N];
  logic [DATA_W-1:0] req_b   [REQ_N];
  logic [FUN_W-1:0]  req_fun [REQ_N];

  slot_state_e       slot_q    [REQ_N];
  slot_state_e       slot_d    [REQ_N];
  logic [DATA_W-1:0] rsp_s_q   [REQ_N];
  logic [DATA_W-1:0] rsp_s_d   [REQ_N];
  logic [2:0]        rsp_zvn_q [REQ_N];
  logic [2:0]        rsp_zvn_d [REQ_N];

  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [FUN_W-1:0]  alu_fun_q, alu_fun_d;
  logic              alu_sign_q, alu_sign_d;
  logic              s1_valid_q, s1_valid_d;
  logic              tag_q, tag_d;

  assign req_valid  = {req1.valid, req0.valid};
  assign req_sign   = {req1.sign, req0.sign};
  assign rsp_ack    = {req1.rsp_ack, req0.rsp_ack};
  assign req_a[0]   = req0.a;
  assign req_a[1]   = req1.a;
  assign req_b[0]   = req0.b;
  assign req_b[1]   = req1.b;
  assign req_fun[0] = req0.fun;
  assign req_fun[1] = req1.fun;

  assign req0.ready     = gnt[0];
  assign req1.ready     = gnt[1];
  assign req0.rsp_valid = (slot_q[0] == SLOT_DONE);
  assign req1.rsp_valid = (slot_q[1] == SLOT_DONE);
  assign req0.rsp_s     = rsp_s_q[0];
  assign req1.rsp_s     = rsp_s_q[1];
  assign req0.rsp_zvn   = rsp_zvn_q[0];
  assign req1.rsp_zvn   = rsp_zvn_q[1];

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_fun  = alu_fun_q;
  assign alu_sign = alu_sign_q;

  // Reset gates eligibility so nothing is accepted while reset is held.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < REQ_N; i++)
      elig[i] = req_valid[i] && (slot_q[i] == SLOT_IDLE) && !reset;
  end

  alu_rr_arbiter u_arb (
`ifndef ALU_ARB_FIXED_PRIO_EN
    .clk   (clk),
    .reset (reset),
`endif
    .elig  (elig),
    .gnt   (gnt)
  );

  // Stage0: operands hold their last value when nothing is granted.
  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_fun_d  = alu_fun_q;
    alu_sign_d = alu_sign_q;
    s1_valid_d = 1'b0;
    tag_d      = tag_q;
    for (int unsigned i = 0; i < REQ_N; i++) begin
      if (gnt[i]) begin
        alu_a_d    = req_a[i];
        alu_b_d    = req_b[i];
        alu_fun_d  = req_fun[i];
        alu_sign_d = req_sign[i];
        s1_valid_d = 1'b1;
        tag_d      = 1'(i);
      end
    end
  end

  // Slot FSMs; the response buffer is only written on the ISSUED -> DONE step.
  always_comb begin
    for (int unsigned i = 0; i < REQ_N; i++) begin
      slot_d[i]    = slot_q[i];
      rsp_s_d[i]   = rsp_s_q[i];
      rsp_zvn_d[i] = rsp_zvn_q[i];
      case (slot_q[i])
        SLOT_IDLE:   if (gnt[i]) slot_d[i] = SLOT_ISSUED;
        SLOT_ISSUED: if (s1_valid_q && (tag_q == 1'(i))) begin
          slot_d[i]    = SLOT_DONE;
          rsp_s_d[i]   = alu_s;
          rsp_zvn_d[i] = {alu_z, alu_v, alu_n};
        end
        SLOT_DONE:   if (rsp_ack[i]) slot_d[i] = SLOT_IDLE;
        default:     slot_d[i] = SLOT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < REQ_N; i++) begin
        slot_q[i]    <= SLOT_IDLE;
        rsp_s_q[i]   <= '0;
        rsp_zvn_q[i] <= '0;
      end
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_fun_q  <= '0;
      alu_sign_q <= 1'b0;
      s1_valid_q <= 1'b0;
      tag_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < REQ_N; i++) begin
        slot_q[i]    <= slot_d[i];
        rsp_s_q[i]   <= rsp_s_d[i];
        rsp_zvn_q[i] <= rsp_zvn_d[i];
      end
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_fun_q  <= alu_fun_d;
      alu_sign_q <= alu_sign_d;
      s1_valid_q <= s1_valid_d;
      tag_q      <= tag_d;
    end
  end

endmodule
